// File: rtl/m2vidct_sched_pkg.sv
// Shared types and constants for the MPEG2 IDCT slot scheduler.
// The stage tag width here sets the width of the per-block tag inside the page pipeline.
package m2vidct_sched_pkg;

  localparam int PIPE_DEPTH  = 3;
  localparam int STAGE_IDX_W = 3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LAUNCH  = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;
  localparam logic [1:0] ST_PRESENT = 2'd3;

  typedef struct packed {
    logic                   valid;
    logic                   coded;
    logic [STAGE_IDX_W-1:0] idx;
  } stage_t;

endpackage

// File: rtl/m2vidct_sched_if.sv
// Block-request channel from the decoder and page hand-off channel to motion compensation.
interface m2vidct_sched_if #(
  parameter int IDX_W = 3
) ();

  logic             blk_req;
  logic             blk_coded;
  logic [IDX_W-1:0] blk_idx;
  logic             blk_ack;

  logic             out_valid;
  logic             out_coded;
  logic [IDX_W-1:0] out_idx;
  logic             out_done;

  // Environment side: decoder plus pixel consumer.
  modport master (
    output blk_req, blk_coded, blk_idx, out_done,
    input  blk_ack, out_valid, out_coded, out_idx
  );

  // Scheduler side.
  modport slave (
    input  blk_req, blk_coded, blk_idx, out_done,
    output blk_ack, out_valid, out_coded, out_idx
  );

endinterface

// File: rtl/m2vidct_sched.sv
// Slot scheduler for the IDCT: launches column/row passes, shifts blocks through the
// three-page pipeline, presents finished pages and drains the pipeline on flush.
module m2vidct_sched
  import m2vidct_sched_pkg::*;
#(
  parameter int IDX_W = STAGE_IDX_W
) (
  input  logic           clk,
  input  logic           softreset,
  m2vidct_sched_if.slave bus,
  input  logic           flush_req,
  output logic           flush_done,
  input  logic           ready_idct,
  output logic           block_start,
  output logic           s1_enable,
  output logic           s2_enable,
  output logic           idle
);

  // st[0]: column pass, st[1]: row pass, st[2]: page being presented.
  stage_t [PIPE_DEPTH-1:0] st;
  stage_t                  st_new;

  logic [1:0]       state;
  logic             flush_pending;
  logic             blk_ack_q;
  logic             out_valid_q;
  logic             out_coded_q;
  logic [IDX_W-1:0] out_idx_q;

  logic take, drain, go, empty, flush_clear;

  assign take        = bus.blk_req;
  assign drain       = flush_pending & (st[0].valid | st[1].valid);
  assign go          = (state == ST_IDLE) & ready_idct & ~out_valid_q & (take | drain);
  assign empty       = ~st[0].valid & ~st[1].valid;
  assign flush_clear = flush_pending & (state == ST_IDLE) & empty & ~out_valid_q;
  assign st_new      = '{valid: take, coded: bus.blk_coded & take, idx: bus.blk_idx};

  assign flush_done    = flush_clear;
  assign bus.blk_ack   = blk_ack_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_coded = out_coded_q;
  assign bus.out_idx   = out_idx_q;
  assign idle          = (state == ST_IDLE) & ~st[0].valid & ~st[1].valid & ~st[2].valid
                       & ~out_valid_q;

  // NOTE: every register here is written with <= so all stages shift off the
  // same pre-edge values; a blocking shift would ripple a block through in one cycle.
  always_ff @(posedge clk) begin
    if (softreset) begin
      st            <= '0;
      state         <= ST_IDLE;
      flush_pending <= 1'b0;
      blk_ack_q     <= 1'b0;
      block_start   <= 1'b0;
      s1_enable     <= 1'b0;
      s2_enable     <= 1'b0;
      out_valid_q   <= 1'b0;
      out_coded_q   <= 1'b0;
      out_idx_q     <= '0;
    end else begin
      block_start <= 1'b0;
      blk_ack_q   <= 1'b0;
      s1_enable   <= 1'b0;
      s2_enable   <= 1'b0;

      if (flush_clear)    flush_pending <= 1'b0;
      else if (flush_req) flush_pending <= 1'b1;

      if (out_valid_q && bus.out_done) out_valid_q <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (go) begin
            // s2 uses the block leaving the column pass, i.e. the pre-shift st[0].
            st[0]       <= st_new;
            st[1]       <= st[0];
            st[2]       <= st[1];
            block_start <= 1'b1;
            blk_ack_q   <= take;
            s1_enable   <= st_new.coded;
            s2_enable   <= st[0].valid & st[0].coded;
            state       <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: state <= (s1_enable | s2_enable) ? ST_RUN : ST_PRESENT;
        ST_RUN: begin
          if (ready_idct) state <= ST_PRESENT;
        end
        ST_PRESENT: begin
          // The page moves into the output registers, so the stage is freed here.
          if (st[2].valid) begin
            out_valid_q  <= 1'b1;
            out_coded_q  <= st[2].coded;
            out_idx_q    <= st[2].idx;
            st[2].valid  <= 1'b0;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m2vidct_sched.sv
// Scoreboard bench for m2vidct_sched: directed block sequences, an IDCT busy model,
// a consumer with programmable read latency, and a monitor checking slots and pages.
module tb_m2vidct_sched;

  localparam int RUN_LEN = 4;

  logic       clk = 1'b0;
  logic       softreset = 1'b1;
  logic       flush_req = 1'b0;
  logic       flush_done;
  logic       ready_idct = 1'b1;
  logic       block_start, s1_enable, s2_enable, idle;

  m2vidct_sched_if #(.IDX_W(3)) bus ();

  m2vidct_sched #(.IDX_W(3)) dut (
    .clk         (clk),
    .softreset   (softreset),
    .bus         (bus),
    .flush_req   (flush_req),
    .flush_done  (flush_done),
    .ready_idct  (ready_idct),
    .block_start (block_start),
    .s1_enable   (s1_enable),
    .s2_enable   (s2_enable),
    .idle        (idle)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int n_slots = 0;
  int n_flush_done = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int cons_delay = 4;
  int busy = 0;
  logic ov_prev = 1'b0;

  logic [2:0] slot_q[$];  // {s1, s2, ack}
  logic [3:0] page_q[$];  // {coded, idx}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // IDCT: busy for RUN_LEN cycles after any slot with an active pass.
  initial forever begin
    @(posedge clk); #1;
    if (block_start && (s1_enable || s2_enable)) busy = RUN_LEN;
    else if (busy > 0) busy--;
    ready_idct = (busy == 0);
  end

  // Consumer: finishes each page cons_delay cycles after it appears.
  initial begin
    bus.out_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.out_valid) begin
        repeat (cons_delay) @(posedge clk);
        #1 bus.out_done = 1'b1;
        done_cyc = cyc;
        @(posedge clk); #1 bus.out_done = 1'b0;
      end
    end
  end

  // Monitor: compares every slot start and every new page against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (block_start) begin
      start_cyc = cyc;
      n_slots++;
      check("start_while_presenting", {31'd0, bus.out_valid}, 32'd0);
      if (slot_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_slot: got s1=%0b s2=%0b ack=%0b, required no slot",
                 s1_enable, s2_enable, bus.blk_ack);
      end else begin
        check("slot_s1_s2_ack", {29'd0, s1_enable, s2_enable, bus.blk_ack},
              {29'd0, slot_q.pop_front()});
      end
    end
    if (bus.out_valid && !ov_prev) begin
      if (page_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_page: got coded=%0b idx=%0d, required no page",
                 bus.out_coded, bus.out_idx);
      end else begin
        check("page_coded_idx", {28'd0, bus.out_coded, bus.out_idx}, {28'd0, page_q.pop_front()});
      end
    end
    if (flush_done) n_flush_done++;
    ov_prev = bus.out_valid;
  end

  task automatic send_block(input logic coded, input logic [2:0] idx);
    bit got = 0;
    bus.blk_req = 1'b1;
    bus.blk_coded = coded;
    bus.blk_idx = idx;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (bus.blk_ack) got = 1;
    end
    if (!got) check("blk_ack_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.blk_req = 1'b0;
  endtask

  task automatic pulse_flush();
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
  endtask

  task automatic wait_idle();
    bit got = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (idle) got = 1;
    end
    if (!got) check("idle_timeout", 32'd0, 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string name);
    check({name, "_outputs"},
          {22'd0, block_start, s1_enable, s2_enable, bus.blk_ack, flush_done,
           bus.out_valid, bus.out_coded, bus.out_idx},
          32'd0);
    check({name, "_idle"}, {31'd0, idle}, 32'd1);
  endtask

  initial begin
    int f0;
    int s0;
    bus.blk_req = 1'b0;
    bus.blk_coded = 1'b0;
    bus.blk_idx = '0;

    repeat (3) @(posedge clk);
    #1 softreset = 1'b0;
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;

    // Single coded block, then drain.
    slot_q.push_back(3'b101); slot_q.push_back(3'b010); slot_q.push_back(3'b000);
    page_q.push_back({1'b1, 3'd2});
    f0 = n_flush_done;
    send_block(1'b1, 3'd2);
    pulse_flush();
    wait_idle();
    check("single_flush_done", n_flush_done, f0 + 1);

    // Six back-to-back coded blocks.
    slot_q.push_back(3'b101);
    for (int i = 1; i < 6; i++) slot_q.push_back(3'b111);
    slot_q.push_back(3'b010); slot_q.push_back(3'b000);
    for (int i = 0; i < 6; i++) page_q.push_back({1'b1, 3'(i)});
    f0 = n_flush_done;
    for (int i = 0; i < 6; i++) send_block(1'b1, 3'(i));
    pulse_flush();
    wait_idle();
    check("six_flush_done", n_flush_done, f0 + 1);

    // Uncoded block between two coded ones.
    slot_q.push_back(3'b101); slot_q.push_back(3'b011); slot_q.push_back(3'b101);
    slot_q.push_back(3'b010); slot_q.push_back(3'b000);
    page_q.push_back({1'b1, 3'd0}); page_q.push_back({1'b0, 3'd1}); page_q.push_back({1'b1, 3'd2});
    send_block(1'b1, 3'd0);
    send_block(1'b0, 3'd1);
    send_block(1'b1, 3'd2);
    pulse_flush();
    wait_idle();

    // Consumer stall with a block waiting.
    cons_delay = 50;
    slot_q.push_back(3'b101); slot_q.push_back(3'b111); slot_q.push_back(3'b111);
    slot_q.push_back(3'b111); slot_q.push_back(3'b010); slot_q.push_back(3'b000);
    for (int i = 3; i < 7; i++) page_q.push_back({1'b1, 3'(i)});
    send_block(1'b1, 3'd3);
    send_block(1'b1, 3'd4);
    send_block(1'b1, 3'd5);
    send_block(1'b1, 3'd6);
    check("stall_launch_gap", start_cyc - done_cyc, 32'd2);
    pulse_flush();
    wait_idle();
    cons_delay = 4;

    // Soft reset in RUN with two blocks in flight.
    slot_q.push_back(3'b101); slot_q.push_back(3'b111);
    send_block(1'b1, 3'd1);
    send_block(1'b1, 3'd2);
    softreset = 1'b1;
    @(posedge clk); #1 softreset = 1'b0;
    @(negedge clk);
    check_quiet("softreset");
    @(posedge clk); #1;
    slot_q.push_back(3'b101); slot_q.push_back(3'b010); slot_q.push_back(3'b000);
    page_q.push_back({1'b1, 3'd7});
    send_block(1'b1, 3'd7);
    pulse_flush();
    wait_idle();

    // Flush with an empty pipeline.
    s0 = n_slots;
    pulse_flush();
    @(negedge clk);
    check("empty_flush_done", {31'd0, flush_done}, 32'd1);
    repeat (6) @(posedge clk);
    #1;
    check("empty_flush_no_start", n_slots, s0);

    check("slot_queue_drained", slot_q.size(), 32'd0);
    check("page_queue_drained", page_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
